// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory-side port of the
// memory port arbiter. The arbiter uses the slave view; the requesters
// and the memory together use the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // requester 0
    logic              r0_req;
    logic              r0_write;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_done;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_err;
    // requester 1
    logic              r1_req;
    logic              r1_write;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_done;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_err;
    // memory side
    logic              m_valid;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_error;

    modport slave (
        input  r0_req, r0_write, r0_addr, r0_wdata,
        output r0_gnt, r0_done, r0_rdata, r0_err,
        input  r1_req, r1_write, r1_addr, r1_wdata,
        output r1_gnt, r1_done, r1_rdata, r1_err,
        output m_valid, m_write, m_addr, m_wdata,
        input  m_ready, m_rdata, m_error
    );

    modport master (
        output r0_req, r0_write, r0_addr, r0_wdata,
        input  r0_gnt, r0_done, r0_rdata, r0_err,
        output r1_req, r1_write, r1_addr, r1_wdata,
        input  r1_gnt, r1_done, r1_rdata, r1_err,
        input  m_valid, m_write, m_addr, m_wdata,
        output m_ready, m_rdata, m_error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of a
// single-port memory. One access in flight at a time; out-of-range
// addresses are rejected locally and never reach the memory.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 2048,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic                   last_q, last_d;
    logic                   id_q, id_d;
    logic                   wr_q, wr_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [1:0]             gnt_q, gnt_d;
    logic [1:0]             done_q, done_d;
    logic [1:0]             err_q, err_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_write_q, m_write_d;
    logic [ADDR_W-1:0]      m_addr_q, m_addr_d;
    logic [DATA_W-1:0]      m_wdata_q, m_wdata_d;
    logic                   busy_q, busy_d;

    logic                   sel_any;
    logic                   sel_id;
    logic                   sel_write;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic                   sel_oor;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    always_comb begin
        sel_any   = bus.r0_req | bus.r1_req;
        sel_id    = (bus.r0_req & bus.r1_req) ? ~last_q : bus.r1_req;
        sel_write = sel_id ? bus.r1_write : bus.r0_write;
        sel_addr  = sel_id ? bus.r1_addr  : bus.r0_addr;
        sel_wdata = sel_id ? bus.r1_wdata : bus.r0_wdata;
        sel_oor   = (32'(sel_addr) >= 32'(DEPTH));
    end

    // Sequencer next-state: IDLE -> ISSUE -> WAIT -> DONE, or IDLE -> DONE on a range error.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        err_d     = 2'b00;
        rdata_d   = rdata_q;
        m_valid_d = m_valid_q;
        m_write_d = m_write_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    id_d          = sel_id;
                    wr_d          = sel_write;
                    last_d        = sel_id;
                    gnt_d[sel_id] = 1'b1;
                    if (sel_oor) begin
                        // m_* keep the previous command; memory is never touched
                        state_d = ST_DONE;
                    end else begin
                        m_valid_d = 1'b1;
                        m_write_d = sel_write;
                        m_addr_d  = sel_addr;
                        m_wdata_d = sel_wdata;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                m_valid_d = 1'b0;
                cnt_d     = 4'd0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.m_ready) begin
                    if (!wr_q) begin
                        rdata_d[id_q] = bus.m_rdata;
                    end
                    done_d[id_q] = 1'b1;
                    err_d[id_q]  = bus.m_error;
                    state_d      = ST_DONE;
                end else if (cnt_q == 4'(TIMEOUT - 1)) begin
                    done_d[id_q] = 1'b1;
                    err_d[id_q]  = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                // Entered from WAIT the done pulse is already out; entered from
                // IDLE (range error) it still has to be issued, one cycle after gnt.
                if (done_q == 2'b00) begin
                    done_d[id_q] = 1'b1;
                    err_d[id_q]  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; rst low at an edge abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            wr_q      <= 1'b0;
            cnt_q     <= 4'd0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            rdata_q   <= '0;
            m_valid_q <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            m_valid_q <= m_valid_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.r0_gnt   = gnt_q[0];
    assign bus.r0_done  = done_q[0];
    assign bus.r0_err   = err_q[0];
    assign bus.r0_rdata = rdata_q[0];
    assign bus.r1_gnt   = gnt_q[1];
    assign bus.r1_done  = done_q[1];
    assign bus.r1_err   = err_q[1];
    assign bus.r1_rdata = rdata_q[1];
    assign bus.m_valid  = m_valid_q;
    assign bus.m_write  = m_write_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: registered memory model, scoreboard of
// expected completions, one task per scenario.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .DEPTH(2048), .TIMEOUT(15)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    typedef struct {
        int          id;
        int          lat;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic        stall    = 1'b0;
    logic [15:0] mem_model [0:2047];
    logic [15:0] ref_mem   [0:2047];
    int          mv_count  = 0;
    int          mv_double = 0;
    int          oob_hits  = 0;
    int          overlap   = 0;
    logic        mv_prev   = 1'b0;

    // Memory model: samples m_valid at an edge, answers one cycle later.
    always @(posedge clk) begin
        bus.m_ready <= 1'b0;
        bus.m_error <= 1'b0;
        mv_prev     <= bus.m_valid;
        if (bus.m_valid) begin
            mv_count <= mv_count + 1;
            if (mv_prev) mv_double <= mv_double + 1;
            if (bus.m_addr >= 16'd2048) begin
                oob_hits <= oob_hits + 1;
            end else if (!stall) begin
                bus.m_ready <= 1'b1;
                if (bus.m_write) mem_model[bus.m_addr[10:0]] <= bus.m_wdata;
                else             bus.m_rdata <= mem_model[bus.m_addr[10:0]];
            end
        end
    end

    // gnt and done must never share a cycle
    always @(negedge clk) begin
        if (rst === 1'b1 && (bus.r0_gnt | bus.r1_gnt) && (bus.r0_done | bus.r1_done))
            overlap <= overlap + 1;
    end

    // One access from one requester; returns observed latencies (edges counted
    // from the sampling edge as 1) and completion data. Leaves one idle edge after.
    task automatic access(input int id, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, output int gnt_lat, output int done_lat,
                          output logic [15:0] rd, output logic er);
        gnt_lat  = -1;
        done_lat = -1;
        rd       = '0;
        er       = 1'b0;
        if (id == 0) begin
            bus.r0_write = wr; bus.r0_addr = addr; bus.r0_wdata = wdata; bus.r0_req = 1'b1;
        end else begin
            bus.r1_write = wr; bus.r1_addr = addr; bus.r1_wdata = wdata; bus.r1_req = 1'b1;
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (gnt_lat < 0 && ((id == 0) ? bus.r0_gnt : bus.r1_gnt)) gnt_lat = n;
            if ((id == 0) ? bus.r0_done : bus.r1_done) begin
                done_lat = n;
                rd = (id == 0) ? bus.r0_rdata : bus.r1_rdata;
                er = (id == 0) ? bus.r0_err : bus.r1_err;
                break;
            end
        end
        if (id == 0) bus.r0_req = 1'b0;
        else         bus.r1_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int dl;
        rst = 1'b0;
        bus.r0_write = 1'b0; bus.r0_addr = 16'd0; bus.r0_wdata = 16'd0; bus.r0_req = 1'b1;
        bus.r1_write = 1'b0; bus.r1_addr = 16'd1; bus.r1_wdata = 16'd0; bus.r1_req = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err,
                 bus.m_valid, bus.m_write, busy} !== 9'd0 ||
                {bus.r0_rdata, bus.r1_rdata, bus.m_addr, bus.m_wdata} !== 64'd0) begin
                failures++;
                $display("FAIL reset_outputs: cycle %0d gnt=%b%b done=%b%b m_valid=%b busy=%b m_addr=%h, required all zero",
                         c, bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done, bus.m_valid, busy, bus.m_addr);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.r0_gnt, bus.r1_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL reset_first_grant: r0_gnt,r1_gnt=%b%b required 10", bus.r0_gnt, bus.r1_gnt);
        end
        bus.r1_req = 1'b0;
        dl = -1;
        for (int n = 2; n <= 10; n++) begin
            @(posedge clk); #1;
            if (bus.r0_done) begin dl = n; break; end
        end
        bus.r0_req = 1'b0;
        checks++;
        if (dl != 3 || bus.r0_err !== 1'b0 || bus.r0_rdata !== 16'd0) begin
            failures++;
            $display("FAIL reset_first_txn: done_lat=%0d err=%b rdata=%h required 3 0 0000", dl, bus.r0_err, bus.r0_rdata);
        end
        $display("txn reset: r0 read addr 0 done_lat=%0d", dl);
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int gl, dl, mv0;
        logic [15:0] rd;
        logic er;
        exp_t e;
        sb.push_back('{0, 3, 16'd0, 1'b0});
        mv0 = mv_count;
        access(0, 1'b1, 16'd5, 16'd6, gl, dl, rd, er);
        ref_mem[5] = 16'd6;
        e = sb.pop_front();
        $display("txn single: r0 write addr 5 gnt_lat=%0d done_lat=%0d err=%b", gl, dl, er);
        checks++;
        if (gl != 1 || dl != e.lat || er !== e.err) begin
            failures++;
            $display("FAIL single_write: gnt_lat=%0d done_lat=%0d err=%b required 1 %0d %b", gl, dl, er, e.lat, e.err);
        end
        checks++;
        if (mv_count - mv0 != 1) begin
            failures++;
            $display("FAIL single_write_mvalid: m_valid cycles=%0d required 1", mv_count - mv0);
        end
        checks++;
        if ({bus.m_write, bus.m_addr, bus.m_wdata} !== {1'b1, 16'd5, 16'd6} || bus.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL m_hold: m_valid=%b m_write=%b m_addr=%h m_wdata=%h required 0 1 0005 0006",
                     bus.m_valid, bus.m_write, bus.m_addr, bus.m_wdata);
        end
        sb.push_back('{0, 3, ref_mem[5], 1'b0});
        mv0 = mv_count;
        access(0, 1'b0, 16'd5, 16'd0, gl, dl, rd, er);
        e = sb.pop_front();
        $display("txn single: r0 read addr 5 rdata=%h done_lat=%0d err=%b", rd, dl, er);
        checks++;
        if (rd !== e.rdata || er !== e.err || dl != e.lat || mv_count - mv0 != 1) begin
            failures++;
            $display("FAIL single_read: rdata=%h err=%b done_lat=%0d mv=%0d required %h %b %0d 1",
                     rd, er, dl, mv_count - mv0, e.rdata, e.err, e.lat);
        end
    endtask

    task automatic test_contention();
        int gl, dl, got, expv, done_cnt;
        logic [15:0] rd;
        logic er;
        logic r0_back, r1_back;
        int gq[$];
        exp_t e;
        // preload; r1 goes last so the first tie goes to r0
        access(0, 1'b1, 16'd0, 16'd1, gl, dl, rd, er); ref_mem[0] = 16'd1;
        access(1, 1'b1, 16'd1, 16'd2, gl, dl, rd, er); ref_mem[1] = 16'd2;
        for (int k = 0; k < 20; k++) begin
            gq.push_back(k % 2);
            sb.push_back('{k % 2, 0, ref_mem[k % 2], 1'b0});
        end
        done_cnt = 0;
        r0_back = 1'b0;
        r1_back = 1'b0;
        bus.r0_write = 1'b0; bus.r0_addr = 16'd0;
        bus.r1_write = 1'b0; bus.r1_addr = 16'd1;
        bus.r0_req = 1'b1;
        bus.r1_req = 1'b1;
        for (int cyc = 0; cyc < 300 && done_cnt < 20; cyc++) begin
            @(posedge clk); #1;
            if (r0_back) begin bus.r0_req = 1'b1; r0_back = 1'b0; end
            if (r1_back) begin bus.r1_req = 1'b1; r1_back = 1'b0; end
            if (bus.r0_gnt || bus.r1_gnt) begin
                got  = (bus.r0_gnt && bus.r1_gnt) ? 2 : (bus.r1_gnt ? 1 : 0);
                expv = (gq.size() > 0) ? gq.pop_front() : -1;
                checks++;
                if (got != expv) begin
                    failures++;
                    $display("FAIL contention_grant: granted r%0d required r%0d", got, expv);
                end
            end
            if (bus.r0_done || bus.r1_done) begin
                got = bus.r1_done ? 1 : 0;
                rd  = got ? bus.r1_rdata : bus.r0_rdata;
                er  = got ? bus.r1_err : bus.r0_err;
                done_cnt++;
                $display("txn contention %0d: r%0d read rdata=%h err=%b", done_cnt, got, rd, er);
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL contention_done: unexpected done from r%0d, required none", got);
                end else begin
                    e = sb.pop_front();
                    if (got != e.id || rd !== e.rdata || er !== e.err) begin
                        failures++;
                        $display("FAIL contention_done: r%0d rdata=%h err=%b required r%0d %h %b",
                                 got, rd, er, e.id, e.rdata, e.err);
                    end
                end
                if (got == 0) begin bus.r0_req = 1'b0; r0_back = (done_cnt < 20); end
                else          begin bus.r1_req = 1'b0; r1_back = (done_cnt < 20); end
            end
        end
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b0;
        checks++;
        if (done_cnt != 20) begin
            failures++;
            $display("FAIL contention_count: completions=%0d required 20", done_cnt);
        end
        sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL contention_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_out_of_range();
        int gl, dl, mv0, oob0;
        logic [15:0] rd;
        logic er;
        exp_t e;
        mv0  = mv_count;
        oob0 = oob_hits;
        sb.push_back('{1, 2, 16'd0, 1'b1});
        access(1, 1'b0, 16'd2048, 16'd0, gl, dl, rd, er);
        e = sb.pop_front();
        $display("txn oor: r1 read addr 2048 gnt_lat=%0d done_lat=%0d err=%b", gl, dl, er);
        checks++;
        if (gl != 1 || dl != e.lat || er !== e.err) begin
            failures++;
            $display("FAIL oor_read: gnt_lat=%0d done_lat=%0d err=%b required 1 %0d %b", gl, dl, er, e.lat, e.err);
        end
        sb.push_back('{1, 2, 16'd0, 1'b1});
        access(1, 1'b1, 16'd2048, 16'hDEAD, gl, dl, rd, er);
        e = sb.pop_front();
        $display("txn oor: r1 write addr 2048 done_lat=%0d err=%b", dl, er);
        checks++;
        if (dl != e.lat || er !== e.err) begin
            failures++;
            $display("FAIL oor_write: done_lat=%0d err=%b required %0d %b", dl, er, e.lat, e.err);
        end
        checks++;
        if (mv_count != mv0 || oob_hits != oob0 || mem_model[0] !== ref_mem[0]) begin
            failures++;
            $display("FAIL oor_memory: m_valid cycles=%0d oob=%0d mem[0]=%h required 0 0 %h",
                     mv_count - mv0, oob_hits - oob0, mem_model[0], ref_mem[0]);
        end
    endtask

    task automatic test_timeout();
        int gl, dl;
        logic [15:0] rd;
        logic er;
        exp_t e;
        stall = 1'b1;
        sb.push_back('{0, 17, 16'd0, 1'b1});
        access(0, 1'b0, 16'd7, 16'd0, gl, dl, rd, er);
        e = sb.pop_front();
        $display("txn timeout: r0 read addr 7 done_lat=%0d err=%b", dl, er);
        checks++;
        if (dl != e.lat || er !== e.err) begin
            failures++;
            $display("FAIL timeout: done_lat=%0d err=%b required %0d %b", dl, er, e.lat, e.err);
        end
        stall = 1'b0;
        sb.push_back('{1, 3, ref_mem[5], 1'b0});
        access(1, 1'b0, 16'd5, 16'd0, gl, dl, rd, er);
        e = sb.pop_front();
        $display("txn timeout: r1 read addr 5 rdata=%h err=%b", rd, er);
        checks++;
        if (dl != e.lat || rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("FAIL after_timeout: done_lat=%0d rdata=%h err=%b required %0d %h %b",
                     dl, rd, er, e.lat, e.rdata, e.err);
        end
    endtask

    task automatic test_mid_reset();
        int gl, dl, bad, spurious;
        logic [15:0] rd;
        logic er;
        exp_t e;
        bad = 0;
        for (int i = 0; i <= 20; i++) begin
            access(0, 1'b1, 16'(i), 16'(i + 1), gl, dl, rd, er);
            ref_mem[i] = 16'(i + 1);
            if (er !== 1'b0 || dl != 3) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midreset_fill: bad writes=%0d required 0", bad);
        end
        stall = 1'b1;
        bus.r0_write = 1'b0; bus.r0_addr = 16'd3; bus.r0_req = 1'b1;
        @(posedge clk); #1;   // granted
        @(posedge clk); #1;   // ISSUE -> WAIT
        @(posedge clk); #1;   // waiting
        rst = 1'b0;
        bus.r0_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        stall = 1'b0;
        spurious = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.r0_done || bus.r1_done || busy) spurious++;
        end
        $display("txn midreset: abandoned r0 read, spurious activity cycles=%0d", spurious);
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL midreset_abandon: active cycles=%0d required 0", spurious);
        end
        for (int i = 0; i <= 20; i++) begin
            sb.push_back('{0, 3, ref_mem[i], 1'b0});
            access(0, 1'b0, 16'(i), 16'd0, gl, dl, rd, er);
            e = sb.pop_front();
            $display("txn midreset: r0 read addr %0d rdata=%h err=%b", i, rd, er);
            checks++;
            if (rd !== e.rdata || er !== e.err || dl != e.lat) begin
                failures++;
                $display("FAIL midreset_read: addr %0d rdata=%h err=%b done_lat=%0d required %h %b %0d",
                         i, rd, er, dl, e.rdata, e.err, e.lat);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem_model[i] = 16'd0;
            ref_mem[i]   = 16'd0;
        end
        rst = 1'b0;
        bus.r0_req = 1'b0; bus.r0_write = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_req = 1'b0; bus.r1_write = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_out_of_range();
        test_timeout();
        test_mid_reset();
        checks++;
        if (overlap != 0) begin
            failures++;
            $display("FAIL gnt_done_overlap: cycles=%0d required 0", overlap);
        end
        checks++;
        if (mv_double != 0) begin
            failures++;
            $display("FAIL m_valid_width: multi-cycle m_valid events=%0d required 0", mv_double);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the team's 2048x16 single-port memory (valid/write/addr/wdata in; ready/rdata/error out; registered on clk).
- Serialises accesses and issues one single-cycle valid per transaction.
- Range-checks addresses locally; an out-of-range access never reaches the memory.
- Returns a one-cycle done pulse with read data or error to the granted requester.

Parameters:
- ADDR_W, 16, address width on all ports
- DATA_W, 16, data width on all ports
- DEPTH, 2048, number of valid memory words; legal address range is 0..DEPTH-1
- TIMEOUT, 15, maximum WAIT cycles for m_ready before an error completion (4-bit counter)

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous active-low reset (rst==0 at a rising edge resets)
- r0_req  input  1  requester 0 access request; held high with its fields stable until r0_done
- r0_write  input  1  1=write, 0=read
- r0_addr  input  ADDR_W  word address
- r0_wdata  input  DATA_W  write data
- r0_gnt  output  1  one-cycle pulse: request accepted
- r0_done  output  1  one-cycle pulse: transaction complete
- r0_rdata  output  DATA_W  read data; valid while r0_done=1, held until the next r0 read completes
- r0_err  output  1  valid with r0_done: out-of-range address or timeout
- r1_req, r1_write, r1_addr, r1_wdata, r1_gnt, r1_done, r1_rdata, r1_err  same as r0 for requester 1
- m_valid  output  1  memory valid, high for exactly one cycle per access
- m_write  output  1  memory write
- m_addr  output  ADDR_W  memory address
- m_wdata  output  DATA_W  memory write data
- m_ready  input  1  memory ready
- m_rdata  input  DATA_W  memory read data
- m_error  input  1  memory error
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE; last=1, so r0 wins the first tie.
  - All outputs 0, including rdata registers and m_* outputs; timeout counter 0.
  - Reset overrides everything. An access in flight is abandoned: no done pulse, and any memory response is ignored.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No req: stay.
  - One req: select it. Both req: select the requester != last.
  - On selection: latch write/addr/wdata and id; set gnt(id)=1 for one cycle; last<=id.
  - Address >= DEPTH: go to DONE with err=1; m_valid stays 0.
  - Otherwise: m_valid<=1, m_* <= latched command; go to ISSUE.
- ISSUE:
  - One cycle; the memory samples m_valid=1 at this edge.
  - m_valid<=0, counter<=0; go to WAIT.
- WAIT:
  - m_ready==1: capture m_rdata into rX_rdata (reads only; writes leave rX_rdata unchanged); err<=m_error; go to DONE.
  - Otherwise: counter+1. When counter==TIMEOUT-1 with no ready: err<=1, go to DONE.
- DONE:
  - done(id)=1 and err(id) for exactly one cycle; then IDLE.
  - The requester drops req in response to done. Arbitration resumes on the edge after DONE.
- Nominal latency: req sampled in IDLE at edge E0; gnt visible after E0; m_valid high E0..E1; done visible after E2 (3 edges).
- Throughput: one access per 4 cycles.
- Simultaneous requests: strict alternation while both remain asserted.
- A request that drops before gnt is simply not served. Dropping req after gnt is illegal; the arbiter still completes that transaction.
- m_* outputs are held stable at the last command when m_valid=0. gnt and done never both high in the same cycle.

Test Plan:
- Reset: hold rst=0 for 2 cycles with both req=1 -> all outputs 0, no gnt. Release -> r0_gnt first (last=1 tie-break).
- Single requester: r0 writes addr=5, wdata=6, then reads addr=5 -> m_valid one cycle per access; r0_done 3 edges after req sampled; r0_rdata=6, r0_err=0.
- Contention: r0 and r1 both read continuously (addr 0 and 1, preloaded 1 and 2) -> grants alternate r0,r1,r0,r1; each done returns its own data; no starvation over 20 transactions.
- Out of range: r1 reads addr=2048 -> r1_done with r1_err=1 two edges after grant; m_valid never asserted; memory contents unchanged.
- Timeout: memory model holds m_ready=0 -> done with err=1 after TIMEOUT WAIT cycles; next request is served normally.
- Mid-operation reset: rst=0 during WAIT -> state IDLE, no done pulse; a subsequent r0 read of addr=0..20 written with i+1 returns i+1.
